var_latency_queue: RTL and testbench
====================================

Name: var_latency_queue

Overview:
- Parametrised successor of the single-shot data-dependent-latency unit.
- Accepts up to DEPTH outstanding requests. Each request's latency is taken from the low bits of its own data word.
- Results complete strictly in order, as single-cycle done pulses with the data on out. There is no consumer handshake.
- Sits between a producer issuing start/inp and a consumer that samples out whenever done is high.

Parameters:
- WIDTH, 32, data width of inp/out.
- DELAY_BITS, 2, number of low inp bits used as the latency value; 1 <= DELAY_BITS < WIDTH.
- DEPTH, 4, maximum outstanding requests; power of two, >= 2.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request valid; accepted only when ready=1.
- inp  input  WIDTH  request data; inp[DELAY_BITS-1:0] is the extra latency d.
- ready  output  1  high when count < DEPTH.
- done  output  1  one-cycle completion pulse for the head entry.
- out  output  WIDTH  head data when done=1, otherwise all zeros.
- count  output  $clog2(DEPTH+1)  number of entries held.
- overflow  output  1  sticky; set when start=1 while ready=0.

Behaviour:
- Reset (async assert): queue emptied, head counter=0, count=0, overflow=0. Outputs during reset: done=0, out=0, ready=1.
- Storage: circular buffer of DEPTH entries, each holding WIDTH data bits. Delay is re-derived from the stored data's low bits. Read/write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Accept: start=1 and ready=1 in cycle t writes inp at the tail at the edge ending t. The entry is visible from cycle t+1.
- Head timing:
  - An entry becomes head in the first cycle it is the oldest entry held.
  - The head counter (DELAY_BITS wide) is 0 in that cycle and increments every cycle while the head is waiting.
  - done = (count != 0) and (counter == head delay). done and out are combinational from registered state only; there is no path from start or inp.
- Latency into an empty queue: start in cycle t with delay d gives done in cycle t+1+d. With d=0, done is in cycle t+1.
- Back-to-back entries: if entry A's done occurs in cycle u and entry B is already queued, B is head in cycle u+1 and completes in cycle u+1+dB. There is no idle gap beyond this.
- Completion: at the edge ending a done cycle, the head is popped and the counter is reset to 0.
- Simultaneous start and done: both occur and count is unchanged. When count=DEPTH, ready=0 even if done=1 in the same cycle; there is no same-cycle bypass.
- Start into an empty queue while done=0: normal accept; the counter is already 0.
- Full: start with ready=0 is dropped, the queue is unchanged, and overflow is set. overflow clears only on reset.
- Counter wrap: not reachable, because the counter never exceeds a DELAY_BITS-wide delay value.
- Reset mid-operation: all pending entries are discarded; no done is produced for them.

Optional Feature:
- Macro: VAR_LATENCY_QUEUE_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 in cycle t empties the queue and zeroes the counter at the edge ending t. done is forced to 0 in cycle t.
  - A start in the same cycle as flush is ignored and does not set overflow.
  - overflow is not cleared by flush.
- When undefined: the port is absent and all flush logic is removed.

Decomposition:
- Package var_latency_queue_pkg holds:
  - function clog2 for pointer and count widths;
  - localparam-style helpers for pointer width and count width.
- One natural sub-module, var_latency_queue_fifo: circular storage with push/pop/count/full/empty and pointer wrap.
- The top level holds the head counter, the done/out logic, overflow, and the optional flush.

Test Plan:
- Single request: reset, then start with inp=32'h0000_0012 (d=2) in cycle 5 -> done=1 and out=32'h0000_0012 in cycle 8 only; out=0 in every other cycle.
- Zero latency back-to-back: start in cycles 3-6 with inp=32'hA0, A4, A8, AC (all d=0) -> done in cycles 4,5,6,7 with those values in order; count peaks at 1.
- Mixed latency ordering: start inp=32'h13 (d=3) in cycle 2, then 32'h20 (d=0) in cycle 3 -> done in cycle 6 (out=13), then done in cycle 7 (out=20); no reordering.
- Full/overflow with DEPTH=4: five consecutive starts with d=3 from cycle 1 -> ready=0 from cycle 5, the fifth start is dropped, overflow=1 stays high, and exactly four done pulses follow.
- Simultaneous start and done at count=2 -> count stays 2 and the new data completes after the remaining entries.
- Async reset with 3 entries pending, asserted mid-cycle -> done=0, count=0, ready=1 immediately with no clock edge; no stale done after release. With VAR_LATENCY_QUEUE_FLUSH_EN, flush with 3 pending gives the same result while overflow is preserved.

Source files
------------

// File: rtl/var_latency_queue_pkg.sv
// Shared width helpers for the variable-latency in-order completion queue.
package var_latency_queue_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    // Count must represent DEPTH itself, hence depth+1 codes.
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/var_latency_queue_fifo.sv
// Circular buffer of DEPTH entries with wrapping pointers and occupancy count.
module var_latency_queue_fifo
    import var_latency_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow is the modulo wrap.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/var_latency_queue.sv
// Queue of requests completing in order, each after a latency taken from its own data.
// Optional flush input enabled by defining VAR_LATENCY_QUEUE_FLUSH_EN.
module var_latency_queue
    import var_latency_queue_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DELAY_BITS = 2,
    parameter int DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset,
`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       start,
    input  logic [WIDTH-1:0]           inp,
    output logic                       ready,
    output logic                       done,
    output logic [WIDTH-1:0]           out,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow
);

    logic [DELAY_BITS-1:0] head_cnt_q, head_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  flush_w;
    logic                  push, pop, full, empty;
    logic [WIDTH-1:0]      head_data;

`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    var_latency_queue_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (flush_w),
        .push  (push),
        .pop   (pop),
        .wdata (inp),
        .rdata (head_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // done/out depend only on registered state; start/inp only feed push.
    always_comb begin
        ready      = !full;
        done       = !empty && !flush_w
                     && (head_cnt_q == head_data[DELAY_BITS-1:0]);
        out        = done ? head_data : '0;
        push       = start && !full && !flush_w;
        pop        = done;
        overflow_d = overflow_q | (start & full & !flush_w);
        head_cnt_d = head_cnt_q;
        if (flush_w || done || empty) head_cnt_d = '0;
        else                          head_cnt_d = head_cnt_q + DELAY_BITS'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_cnt_q <= head_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_var_latency_queue.sv
// Directed self-checking bench for var_latency_queue (DEPTH=4, DELAY_BITS=2).
module tb_var_latency_queue;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] inp;
    logic        ready;
    logic        done;
    logic [31:0] out;
    logic [2:0]  count;
    logic        overflow;
`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
    logic        flush;
`endif

    int checks;
    int failures;

    var_latency_queue #(.WIDTH(32), .DELAY_BITS(2), .DEPTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
        .flush    (flush),
`endif
        .start    (start),
        .inp      (inp),
        .ready    (ready),
        .done     (done),
        .out      (out),
        .count    (count),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        inp   = '0;
`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
        flush = 1'b0;
`endif
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        inp   = '0;
`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
        flush = 1'b0;
`endif
        #2;
        checks++;
        if (done !== 1'b0 || out !== 32'h0 || ready !== 1'b1 || count !== 3'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: done=%b out=%h ready=%b count=%0d ovf=%b, want 0 0 1 0 0",
                     done, out, ready, count, overflow);
        end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            start = (c == 0);
            inp   = (c == 0) ? 32'h0000_0012 : 32'h0;
            @(negedge clock);
            checks++;
            if (done !== (c == 3) || out !== ((c == 3) ? 32'h12 : 32'h0)) begin
                failures++;
                $display("FAIL single c%0d: done=%b out=%h, want done=%b", c, done, out, (c == 3));
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_zero_latency();
        logic [31:0] vals [4];
        logic [2:0]  exp_cnt [7];
        vals    = '{32'hA0, 32'hA4, 32'hA8, 32'hAC};
        exp_cnt = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            start = (c < 4);
            inp   = (c < 4) ? vals[c] : 32'h0;
            @(negedge clock);
            checks++;
            if (count !== exp_cnt[c]) begin
                failures++;
                $display("FAIL zero_lat_count c%0d: count=%0d want %0d", c, count, exp_cnt[c]);
            end
            checks++;
            if (c >= 1 && c <= 4) begin
                if (done !== 1'b1 || out !== vals[c-1]) begin
                    failures++;
                    $display("FAIL zero_lat_done c%0d: done=%b out=%h want 1 %h", c, done, out, vals[c-1]);
                end
            end else if (done !== 1'b0 || out !== 32'h0) begin
                failures++;
                $display("FAIL zero_lat_idle c%0d: done=%b out=%h want 0 0", c, done, out);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_mixed_order();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            start = (c < 2);
            inp   = (c == 0) ? 32'h13 : (c == 1) ? 32'h20 : 32'h0;
            @(negedge clock);
            checks++;
            if (c == 4) begin
                if (done !== 1'b1 || out !== 32'h13) begin
                    failures++;
                    $display("FAIL mixed_first: done=%b out=%h want 1 13", done, out);
                end
            end else if (c == 5) begin
                if (done !== 1'b1 || out !== 32'h20) begin
                    failures++;
                    $display("FAIL mixed_second: done=%b out=%h want 1 20", done, out);
                end
            end else if (done !== 1'b0) begin
                failures++;
                $display("FAIL mixed_idle c%0d: done=%b want 0", c, done);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_full_overflow();
        logic [31:0] vals [5];
        int          ndone;
        vals  = '{32'h03, 32'h07, 32'h0B, 32'h0F, 32'h13};
        ndone = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            start = (c < 5);
            inp   = (c < 5) ? vals[c] : 32'h0;
            @(negedge clock);
            if (done === 1'b1) ndone++;
            if (c == 4) begin
                checks++;
                if (ready !== 1'b0 || count !== 3'd4 || done !== 1'b1 || out !== 32'h03) begin
                    failures++;
                    $display("FAIL full_c4: ready=%b count=%0d done=%b out=%h want 0 4 1 03",
                             ready, count, done, out);
                end
            end
            if (c == 3) begin
                checks++;
                if (ready !== 1'b1 || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL full_c3: ready=%b ovf=%b want 1 0", ready, overflow);
                end
            end
            if (c == 5 || c == 23) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL full_overflow c%0d: ovf=%b want 1", c, overflow);
                end
            end
            if (c == 5) begin
                checks++;
                if (count !== 3'd3) begin
                    failures++;
                    $display("FAIL full_drop: count=%0d want 3", count);
                end
            end
            if (c == 8 || c == 12 || c == 16) begin
                checks++;
                if (done !== 1'b1 || out !== vals[(c - 4) / 4]) begin
                    failures++;
                    $display("FAIL full_done c%0d: done=%b out=%h want 1 %h", c, done, out, vals[(c - 4) / 4]);
                end
            end
            next_cycle();
        end
        start = 1'b0;
        checks++;
        if (ndone != 4) begin
            failures++;
            $display("FAIL full_done_count: got %0d pulses want 4", ndone);
        end
    endtask

    task automatic test_simul_start_done();
        logic [2:0] exp_cnt [9];
        exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            start = (c < 3);
            inp   = (c == 0) ? 32'h21 : (c == 1) ? 32'h32 : (c == 2) ? 32'h40 : 32'h0;
            @(negedge clock);
            checks++;
            if (count !== exp_cnt[c]) begin
                failures++;
                $display("FAIL simul_count c%0d: count=%0d want %0d", c, count, exp_cnt[c]);
            end
            checks++;
            if (c == 2 || c == 5 || c == 6) begin
                if (done !== 1'b1 || out !== ((c == 2) ? 32'h21 : (c == 5) ? 32'h32 : 32'h40)) begin
                    failures++;
                    $display("FAIL simul_done c%0d: done=%b out=%h", c, done, out);
                end
            end else if (done !== 1'b0) begin
                failures++;
                $display("FAIL simul_idle c%0d: done=%b want 0", c, done);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            start = (c < 3);
            inp   = (c == 0) ? 32'h03 : (c == 1) ? 32'h07 : (c == 2) ? 32'h0B : 32'h0;
            next_cycle();
        end
        start = 1'b0;
        @(negedge clock);
        checks++;
        if (done !== 1'b1 || count !== 3'd3) begin
            failures++;
            $display("FAIL areset_pre: done=%b count=%0d want 1 3", done, count);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || count !== 3'd0 || ready !== 1'b1 || out !== 32'h0) begin
            failures++;
            $display("FAIL areset_now: done=%b count=%0d ready=%b out=%h want 0 0 1 0", done, count, ready, out);
        end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("FAIL areset_stale c%0d: done=%b count=%0d want 0 0", c, done, count);
            end
            next_cycle();
        end
    endtask

`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            start = (c < 5) || (c == 8);
            inp   = (c < 5) ? 32'h03 + 32'(4 * c) : 32'h40;
            flush = (c == 8);
            @(negedge clock);
            if (c == 8) begin
                checks++;
                if (done !== 1'b0 || count !== 3'd3 || out !== 32'h0) begin
                    failures++;
                    $display("FAIL flush_cycle: done=%b count=%0d out=%h want 0 3 0", done, count, out);
                end
            end
            if (c == 9) begin
                checks++;
                if (count !== 3'd0 || ready !== 1'b1 || overflow !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_after: count=%0d ready=%b ovf=%b done=%b want 0 1 1 0",
                             count, ready, overflow, done);
                end
            end
            next_cycle();
        end
        start = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("FAIL flush_stale c%0d: done=%b count=%0d", c, done, count);
            end
            next_cycle();
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_zero_latency();
        test_mixed_order();
        test_full_overflow();
        test_simul_start_done();
        test_async_reset();
`ifdef VAR_LATENCY_QUEUE_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
